// File: rtl/con_cmd_bridge_pkg.sv
// Shared constants for the controller-port command bridge: memory geometry,
// opcodes, response bytes and FSM state encoding.
package con_cmd_bridge_pkg;

  localparam int DATAMEM_BITS  = 12;
  localparam int DATAMEM_WIDTH = 32;

  localparam logic [3:0] CMD_WRITE = 4'h1;
  localparam logic [3:0] CMD_READ  = 4'h2;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_NAK = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_WR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_TX,
    ST_ACK,
    ST_NAK
  } state_t;

  // A word address is legal only if every bit above the memory depth is zero.
  function automatic logic addr_ok(input logic [15:0] a);
    return ~|a[15:DATAMEM_BITS];
  endfunction

endpackage

// File: rtl/con_cmd_bridge.sv
// Parses write/read commands from an rx byte stream into datamem controller-port
// accesses and returns ACK/NAK or 4 read-data bytes (LSB first) on the tx stream.
module con_cmd_bridge
  import con_cmd_bridge_pkg::*;
#(
  parameter int TIMEOUT = 100000,
  parameter int RD_LAT  = 1
) (
  input  logic                     con_clk,
  input  logic                     nrst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic [3:0]               con_write,
  output logic [DATAMEM_BITS-1:0]  con_addr,
  output logic [DATAMEM_WIDTH-1:0] con_in,
  input  logic [DATAMEM_WIDTH-1:0] con_out,
  output logic                     busy,
  output logic                     err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RD_LAT + 1);

  state_t                   state, state_nxt;
  logic                     run;
  logic                     is_write;
  logic [3:0]               mask;
  logic [15:0]              addr;
  logic [DATAMEM_WIDTH-1:0] wdata;
  logic [DATAMEM_WIDTH-1:0] shreg;
  logic [1:0]               bcnt;
  logic [TW-1:0]            tcnt;
  logic [RW-1:0]            rcnt;
  logic                     rx_phase, rx_fire, tx_fire, tmo, rd_latch;

  // run keeps rx_ready low while nrst is asserted and for the first edge after.
  assign rx_phase  = (state == ST_ADDR_HI) || (state == ST_ADDR_LO) || (state == ST_DATA);
  assign rx_ready  = run && ((state == ST_IDLE) || rx_phase);
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_valid  = (state == ST_TX) || (state == ST_ACK) || (state == ST_NAK);
  assign tx_fire   = tx_valid && tx_ready;
  assign tmo       = rx_phase && !rx_fire && (tcnt == TW'(TIMEOUT - 1));
  assign rd_latch  = (state == ST_RD_WAIT) && (rcnt == RW'(RD_LAT - 1));
  assign con_write = (state == ST_WR) ? mask : 4'h0;
  assign con_addr  = addr[DATAMEM_BITS-1:0];
  assign con_in    = wdata;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_TX:   tx_data = shreg[7:0];
      ST_ACK:  tx_data = RSP_ACK;
      ST_NAK:  tx_data = RSP_NAK;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    if (tmo) begin
      state_nxt = ST_IDLE;
      err       = 1'b1;
    end else begin
      case (state)
        ST_IDLE:
          if (rx_fire) begin
            if (rx_data[7:4] == CMD_WRITE || rx_data[7:4] == CMD_READ) begin
              state_nxt = ST_ADDR_HI;
            end else begin
              state_nxt = ST_NAK;
              err       = 1'b1;
            end
          end
        ST_ADDR_HI:
          if (rx_fire) state_nxt = ST_ADDR_LO;
        ST_ADDR_LO:
          if (rx_fire) begin
            if (is_write) begin
              state_nxt = ST_DATA;
            end else if (addr_ok({addr[15:8], rx_data})) begin
              state_nxt = ST_RD_REQ;
            end else begin
              state_nxt = ST_NAK;
              err       = 1'b1;
            end
          end
        ST_DATA:
          if (rx_fire && bcnt == 2'd3) begin
            if (addr_ok(addr)) begin
              state_nxt = ST_WR;
            end else begin
              state_nxt = ST_NAK;
              err       = 1'b1;
            end
          end
        ST_WR:      state_nxt = ST_ACK;
        ST_RD_REQ:  state_nxt = ST_RD_WAIT;
        ST_RD_WAIT: if (rd_latch) state_nxt = ST_TX;
        ST_TX:      if (tx_fire && bcnt == 2'd3) state_nxt = ST_IDLE;
        ST_ACK:     if (tx_fire) state_nxt = ST_IDLE;
        ST_NAK:     if (tx_fire) state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge con_clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      run      <= 1'b0;
      is_write <= 1'b0;
      mask     <= 4'h0;
      addr     <= 16'h0000;
      wdata    <= '0;
      shreg    <= '0;
      bcnt     <= 2'd0;
      tcnt     <= '0;
      rcnt     <= '0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;

      // Inter-byte timer: only counts while a command is half-received.
      if (rx_phase && !rx_fire && !tmo) tcnt <= tcnt + 1'b1;
      else                               tcnt <= '0;

      if (state == ST_RD_WAIT) rcnt <= rcnt + 1'b1;
      else                     rcnt <= '0;

      if (state == ST_IDLE) begin
        bcnt <= 2'd0;
        if (rx_fire) begin
          is_write <= (rx_data[7:4] == CMD_WRITE);
          mask     <= rx_data[3:0];
        end
      end

      if (state == ST_ADDR_HI && rx_fire) addr[15:8] <= rx_data;
      if (state == ST_ADDR_LO && rx_fire) addr[7:0]  <= rx_data;

      if (state == ST_DATA && rx_fire) begin
        wdata[{bcnt, 3'b000} +: 8] <= rx_data;
        bcnt                      <= bcnt + 2'd1;
      end

      if (rd_latch) begin
        shreg <= con_out;
      end else if (state == ST_TX && tx_fire) begin
        shreg <= shreg >> 8;
        bcnt  <= bcnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_con_cmd_bridge.sv
// Randomized and directed scoreboard bench for con_cmd_bridge with a datamem model.
module tb_con_cmd_bridge;
  import con_cmd_bridge_pkg::*;

  typedef struct packed {
    logic [3:0]  m;
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  logic                     con_clk = 1'b0;
  logic                     nrst;
  logic                     rx_valid;
  logic [7:0]               rx_data;
  logic                     rx_ready;
  logic                     tx_valid;
  logic [7:0]               tx_data;
  logic                     tx_ready;
  logic [3:0]               con_write;
  logic [DATAMEM_BITS-1:0]  con_addr;
  logic [DATAMEM_WIDTH-1:0] con_in;
  logic [DATAMEM_WIDTH-1:0] con_out;
  logic                     busy;
  logic                     err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int exp_err = 0;
  logic bp_hold = 1'b0;
  logic bp_rand = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0]  txq[$];
  wr_t         wrq[$];
  logic [31:0] ref_mem[0:4095];
  logic [31:0] dmem[0:4095];

  con_cmd_bridge #(.TIMEOUT(16), .RD_LAT(1)) dut (
    .con_clk(con_clk), .nrst(nrst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .con_write(con_write), .con_addr(con_addr), .con_in(con_in), .con_out(con_out),
    .busy(busy), .err(err)
  );

  always #5 con_clk = ~con_clk;

  // Datamem: byte-enabled write, synchronous read one edge after address.
  always @(posedge con_clk) begin
    for (int b = 0; b < 4; b++)
      if (con_write[b]) dmem[con_addr][8*b +: 8] <= con_in[8*b +: 8];
    con_out <= dmem[con_addr];
  end

  always @(posedge con_clk) begin
    #1;
    if (bp_hold)      tx_ready = 1'b0;
    else if (bp_rand) tx_ready = ($urandom_range(0, 2) != 0);
    else              tx_ready = 1'b1;
  end

  // Monitor: pops the scoreboards whenever the DUT presents a transfer.
  always @(negedge con_clk) begin
    if (!nrst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!tx_valid || tx_data !== prev_data) begin
          errors++;
          $display("FAIL tx_stable got vld=%0b dat=%02h required vld=1 dat=%02h", tx_valid, tx_data, prev_data);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        checks++;
        if (txq.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected got %02h required none", tx_data);
        end else begin
          logic [7:0] e;
          e = txq.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte got %02h required %02h", tx_data, e);
          end
        end
      end
      if (con_write != 4'h0) begin
        checks++;
        if (wrq.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected got we=%h a=%03h d=%08h required none", con_write, con_addr, con_in);
        end else begin
          wr_t w;
          w = wrq.pop_front();
          if (con_write !== w.m || con_addr !== w.a || con_in !== w.d) begin
            errors++;
            $display("FAIL wr_access got we=%h a=%03h d=%08h required we=%h a=%03h d=%08h",
                     con_write, con_addr, con_in, w.m, w.a, w.d);
          end
        end
      end
      if (err) err_seen++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge con_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge con_clk);
    while (!rx_ready && n < 200) begin
      n++;
      @(negedge con_clk);
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_accept byte %02h got never-ready required accepted", b);
    end
    @(posedge con_clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(negedge con_clk);
      if (!busy && txq.size() == 0 && wrq.size() == 0) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL cmd_done got busy=%0b txq=%0d wrq=%0d required idle and drained", busy, txq.size(), wrq.size());
        txq.delete();
        wrq.delete();
        break;
      end
    end
    checks++;
    if (err_seen != exp_err) begin
      errors++;
      $display("FAIL err_count got %0d required %0d", err_seen, exp_err);
    end
    @(posedge con_clk);
    #1;
  endtask

  // Reference model: decides the whole outcome of a command from its bytes.
  task automatic issue_cmd(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d, input int gmax);
    logic [7:0] bytes[$];
    logic [31:0] w;
    bytes.push_back(op);
    if (op[7:4] == 4'h1) begin
      bytes.push_back(a[15:8]);
      bytes.push_back(a[7:0]);
      for (int b = 0; b < 4; b++) bytes.push_back(d[8*b +: 8]);
      if (a >= 16'd4096) begin
        txq.push_back(8'hEE);
        exp_err++;
      end else begin
        if (op[3:0] != 4'h0) wrq.push_back('{m: op[3:0], a: a[11:0], d: d});
        for (int b = 0; b < 4; b++)
          if (op[b]) ref_mem[a[11:0]][8*b +: 8] = d[8*b +: 8];
        txq.push_back(8'hA5);
      end
    end else if (op[7:4] == 4'h2) begin
      bytes.push_back(a[15:8]);
      bytes.push_back(a[7:0]);
      if (a >= 16'd4096) begin
        txq.push_back(8'hEE);
        exp_err++;
      end else begin
        w = ref_mem[a[11:0]];
        for (int b = 0; b < 4; b++) txq.push_back(w[8*b +: 8]);
      end
    end else begin
      txq.push_back(8'hEE);
      exp_err++;
    end
    foreach (bytes[i]) begin
      if (i != 0) idle($urandom_range(0, gmax));
      send(bytes[i]);
    end
  endtask

  initial begin
    int first_err;
    logic [7:0]  op;
    logic [15:0] a;
    nrst     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = $urandom;
      dmem[i]    = ref_mem[i];
    end
    repeat (3) @(posedge con_clk);
    #1;
    checks++;
    if ({rx_ready, tx_valid, tx_data, con_write, con_addr, con_in, busy, err} != '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%0b vld=%0b dat=%02h we=%h a=%03h d=%08h busy=%0b err=%0b required all 0",
               rx_ready, tx_valid, tx_data, con_write, con_addr, con_in, busy, err);
    end
    nrst = 1'b1;
    idle(2);

    issue_cmd(8'h1F, 16'h0402, 32'h11223344, 0); wait_done();
    issue_cmd(8'h20, 16'h0402, 32'h0, 0);        wait_done();
    issue_cmd(8'h1F, 16'h0010, 32'h01020304, 1); wait_done();
    issue_cmd(8'h14, 16'h0010, 32'hAABBCCDD, 1); wait_done();
    issue_cmd(8'h20, 16'h0010, 32'h0, 1);        wait_done();
    issue_cmd(8'h10, 16'h0011, 32'hDEADBEEF, 0); wait_done();
    issue_cmd(8'h20, 16'h0011, 32'h0, 0);        wait_done();
    issue_cmd(8'h7F, 16'h0000, 32'h0, 0);        wait_done();
    issue_cmd(8'h20, 16'h0402, 32'h0, 0);        wait_done();
    issue_cmd(8'h20, 16'hFFFF, 32'h0, 0);        wait_done();
    issue_cmd(8'h1F, 16'hFFFF, 32'h55667788, 0); wait_done();
    issue_cmd(8'h2F, 16'h0FFF, 32'h0, 0);        wait_done();

    // Inter-byte timeout: partial write abandoned after the address high byte.
    send(8'h1F);
    send(8'h00);
    first_err = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge con_clk);
      if (err && first_err == 0) first_err = i;
      @(posedge con_clk);
      #1;
    end
    exp_err++;
    checks++;
    if (first_err != 16) begin
      errors++;
      $display("FAIL timeout_cycle got %0d required 16", first_err);
    end
    wait_done();
    issue_cmd(8'h20, 16'h0000, 32'h0, 0); wait_done();

    // Response held off by the consumer for a long stall.
    bp_hold = 1'b1;
    issue_cmd(8'h20, 16'h0402, 32'h0, 0);
    idle(12);
    bp_hold = 1'b0;
    wait_done();

    // Reset in the middle of the data phase must discard the write.
    send(8'h1F); send(8'h00); send(8'h20);
    send(8'h01); send(8'h02); send(8'h03);
    nrst = 1'b0;
    #1;
    checks++;
    if ({rx_ready, tx_valid, tx_data, con_write, con_addr, con_in, busy, err} != '0) begin
      errors++;
      $display("FAIL midreset_outputs got rdy=%0b vld=%0b dat=%02h we=%h a=%03h d=%08h busy=%0b err=%0b required all 0",
               rx_ready, tx_valid, tx_data, con_write, con_addr, con_in, busy, err);
    end
    idle(3);
    nrst = 1'b1;
    idle(2);
    issue_cmd(8'h20, 16'h0020, 32'h0, 0); wait_done();

    // Randomized traffic with random tx backpressure.
    bp_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) | 16'h1000 : 16'($urandom_range(0, 15));
      if (sel == 0) begin
        op = 8'($urandom);
        if (op[7:4] == 4'h1 || op[7:4] == 4'h2) op[7:4] = 4'h9;
      end else if (sel < 5) begin
        op = {4'h1, 4'($urandom)};
      end else begin
        op = {4'h2, 4'($urandom)};
      end
      issue_cmd(op, a, $urandom, 3);
      wait_done();
    end
    bp_rand = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
